spi_apb_initiator: RTL and testbench

- APB3 initiator driving register accesses into the SPI register file (and any other APB target on the same bus) from a simple request/response interface.
- Used by the on-chip sequencer to program the SPI core without a CPU: control1, control2, ssel, FIFO clears, interrupt clears and status polling.
- Issues one APB transfer at a time: SETUP phase, then ACCESS phase, with pready wait states, pslverr capture and optional timeout abort.

---
 rtl/spi_apb_initiator.sv | 145 ++++++++++++++
 tb/tb_spi_apb_initiator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_initiator.sv
// APB3 initiator: turns a request/response handshake into single APB transfers.
// Optional ACCESS-phase timeout abort is enabled with `define SPI_APB_TIMEOUT_EN.
module spi_apb_initiator #(
  parameter int APB_DWIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  sresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [6:0]            req_addr,
  input  logic [APB_DWIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DWIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [6:0]            paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_DWIDTH-1:0] pwdata,
  input  logic [APB_DWIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  busy
);

  localparam logic [APB_DWIDTH-1:0] DZERO = {APB_DWIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic                    timeout_s;
  logic                    accept_s;
  logic                    access_end_s;
  logic                    req_ready_r, rsp_valid_r, rsp_err_r, busy_r;
  logic                    psel_r, penable_r, pwrite_r;
  logic [6:0]              paddr_r;
  logic [APB_DWIDTH-1:0]   pwdata_r, rsp_rdata_r;

`ifdef SPI_APB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_cnt_r;

  // Counts wait-state cycles of the current ACCESS phase.
  always_ff @(posedge pclk) begin
    if (!sresetn) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == ST_SETUP) begin
      tmo_cnt_r <= 8'd0;
    end else if ((state_r == ST_ACCESS) && !pready) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign timeout_s = (state_r == ST_ACCESS) && !pready && ((tmo_cnt_r + 8'd1) == TMO_LIMIT);
`else
  assign timeout_s = 1'b0;
`endif

  assign accept_s     = (state_r == ST_IDLE) && req_valid && req_ready_r;
  assign access_end_s = (state_r == ST_ACCESS) && (pready || timeout_s);

  // State register.
  always_ff @(posedge pclk) begin
    if (!sresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_SETUP;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SETUP:  state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (access_end_s) state_nxt_s = ST_RESP;
        else              state_nxt_s = ST_ACCESS;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered bus and response outputs, decoded from the upcoming state.
  always_ff @(posedge pclk) begin
    if (!sresetn) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= DZERO;
      busy_r      <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= 7'd0;
      pwdata_r    <= DZERO;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      busy_r      <= (state_nxt_s != ST_IDLE);
      psel_r      <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
      penable_r   <= (state_nxt_s == ST_ACCESS);
      if (accept_s) begin
        paddr_r  <= req_addr;
        pwrite_r <= req_write;
        pwdata_r <= req_write ? req_wdata : DZERO;
      end
      // A timeout without pready reports an error with no data.
      if (access_end_s) begin
        rsp_err_r   <= pready ? pslverr : 1'b1;
        rsp_rdata_r <= (pready && !pslverr && !pwrite_r) ? prdata : DZERO;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign busy      = busy_r;
  assign psel      = psel_r;
  assign penable   = penable_r;
  assign pwrite    = pwrite_r;
  assign paddr     = paddr_r;
  assign pwdata    = pwdata_r;

endmodule

// File: tb/tb_spi_apb_initiator.sv
// Self-checking bench for spi_apb_initiator: directed and randomized APB transfers.
module tb_spi_apb_initiator;
  localparam int DW = 8;

  logic          pclk = 1'b0;
  logic          sresetn;
  logic          req_valid, req_ready, req_write;
  logic [6:0]    req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [6:0]    paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr, busy;

  int n_pass  = 0;
  int n_total = 0;

  logic          pend_en = 1'b0;
  logic          pend_wr;
  logic [6:0]    pend_addr;
  logic [DW-1:0] pend_wd;
  time           acc_t[$];

  always #5 pclk = ~pclk;

  spi_apb_initiator #(.APB_DWIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .sresetn(sresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  // One complete transfer; the expected response follows the APB rules directly.
  task automatic run_xfer(input logic wr, input logic [6:0] addr, input logic [DW-1:0] wd,
                          input int waits, input logic [DW-1:0] rd, input logic err, input int hold);
    logic [DW-1:0] exp_rd, exp_wd;
    int budget;
    exp_rd = (wr || err) ? 8'h00 : rd;
    exp_wd = wr ? wd : 8'h00;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b0;
    budget = 0;
    while (req_ready !== 1'b1 && budget < 20) begin
      @(negedge pclk); budget++;
    end
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL accept_wait: req_ready=%b want 1", req_ready);
    else n_pass++;
    @(negedge pclk);
    acc_t.push_back($time - 5);
    req_valid = 1'b0; req_addr = 7'($urandom); req_wdata = 8'($urandom);
    n_total++;
    if ({psel, penable, pwrite, paddr, pwdata, req_ready, busy, rsp_valid} !==
        {1'b1, 1'b0, wr, addr, exp_wd, 1'b0, 1'b1, 1'b0})
      $display("FAIL setup: got %b %b %b %h %h %b %b %b want 1 0 %b %h %h 0 1 0",
               psel, penable, pwrite, paddr, pwdata, req_ready, busy, rsp_valid, wr, addr, exp_wd);
    else n_pass++;
    pready = 1'(($urandom)); pslverr = 1'($urandom);
    for (int i = 0; i <= waits; i++) begin
      @(negedge pclk);
      n_total++;
      if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {1'b1, 1'b1, wr, addr, exp_wd, 1'b0})
        $display("FAIL access%0d: got %b %b %b %h %h %b want 1 1 %b %h %h 0",
                 i, psel, penable, pwrite, paddr, pwdata, rsp_valid, wr, addr, exp_wd);
      else n_pass++;
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : 8'($urandom);
      pslverr = (i == waits) ? err : 1'($urandom);
    end
    @(negedge pclk);
    pready = 1'b0; pslverr = 1'b0; prdata = 8'($urandom);
    n_total++;
    if ({rsp_valid, psel, penable, busy, req_ready, rsp_rdata, rsp_err} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, exp_rd, err})
      $display("FAIL resp: got v=%b psel=%b pen=%b busy=%b rr=%b rd=%h err=%b want 1 0 0 1 0 %h %b",
               rsp_valid, psel, penable, busy, req_ready, rsp_rdata, rsp_err, exp_rd, err);
    else n_pass++;
    if (pend_en) begin
      req_valid = 1'b1; req_write = pend_wr; req_addr = pend_addr; req_wdata = pend_wd;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      n_total++;
      if ({rsp_valid, rsp_rdata, rsp_err, req_ready, psel} !== {1'b1, exp_rd, err, 1'b0, 1'b0})
        $display("FAIL hold%0d: got v=%b rd=%h err=%b rr=%b psel=%b want 1 %h %b 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, psel, exp_rd, err);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    n_total++;
    if ({rsp_valid, req_ready, psel, busy} !== 4'b0100)
      $display("FAIL handshake: got v=%b rr=%b psel=%b busy=%b want 0 1 0 0",
               rsp_valid, req_ready, psel, busy);
    else n_pass++;
    pend_en = 1'b0;
  endtask

  task automatic test_reset();
    sresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 7'd0; req_wdata = 8'd0;
    rsp_ready = 1'b0; prdata = 8'd0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge pclk);
    sresetn = 1'b1;
    @(negedge pclk);
    n_total++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, busy, paddr, pwdata, rsp_rdata, req_ready} !==
        {6'b000000, 7'd0, 8'd0, 8'd0, 1'b1})
      $display("FAIL reset: got %b%b%b%b%b%b %h %h %h rr=%b want 000000 00 00 00 rr=1",
               psel, penable, pwrite, rsp_valid, rsp_err, busy, paddr, pwdata, rsp_rdata, req_ready);
    else n_pass++;
  endtask

  task automatic test_write_read();
    run_xfer(1'b1, 7'h00, 8'h03, 0, 8'h77, 1'b0, 0);
    run_xfer(1'b0, 7'h20, 8'h99, 0, 8'hA5, 1'b0, 0);
  endtask

  task automatic test_wait_states();
    run_xfer(1'b0, 7'h11, 8'h00, 3, 8'h5C, 1'b0, 0);
    run_xfer(1'b1, 7'h12, 8'hC3, 2, 8'hFF, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    acc_t.delete();
    run_xfer(1'b1, 7'h05, 8'h11, 0, 8'h00, 1'b0, 0);
    run_xfer(1'b0, 7'h06, 8'h00, 0, 8'h3E, 1'b0, 0);
    n_total++;
    if (acc_t[1] - acc_t[0] !== 40)
      $display("FAIL b2b_latency: got %0t want 40", acc_t[1] - acc_t[0]);
    else n_pass++;
    pend_en = 1'b1; pend_wr = 1'b1; pend_addr = 7'h33; pend_wd = 8'h4B;
    run_xfer(1'b0, 7'h32, 8'h00, 1, 8'h81, 1'b0, 5);
    run_xfer(1'b1, 7'h33, 8'h4B, 0, 8'h00, 1'b0, 0);
  endtask

  task automatic test_error();
    run_xfer(1'b0, 7'h21, 8'h00, 0, 8'hE7, 1'b1, 0);
    run_xfer(1'b1, 7'h22, 8'h5A, 1, 8'h00, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h20; pready = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    n_total++;
    if (penable !== 1'b1) $display("FAIL mid_access: penable=%b want 1", penable);
    else n_pass++;
    sresetn = 1'b0;
    @(negedge pclk);
    n_total++;
    if ({psel, penable, busy, rsp_valid, req_ready} !== 5'b00001)
      $display("FAIL mid_reset: got %b%b%b%b%b want 00001", psel, penable, busy, rsp_valid, req_ready);
    else n_pass++;
    sresetn = 1'b1;
    @(negedge pclk);
    run_xfer(1'b0, 7'h24, 8'h00, 0, 8'h6D, 1'b0, 0);
  endtask

  task automatic test_timeout();
    int cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h2A; pready = 1'b0; rsp_ready = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 310; i++) begin
      @(negedge pclk);
      if (penable === 1'b1) cnt++;
      else break;
    end
`ifdef SPI_APB_TIMEOUT_EN
    n_total++;
    if ({cnt == 4, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b1, 8'h00})
      $display("FAIL timeout: access=%0d v=%b err=%b rd=%h want 4 1 1 00", cnt, rsp_valid, rsp_err, rsp_rdata);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
`else
    n_total++;
    if ({cnt >= 300, psel, busy, rsp_valid} !== 4'b1110)
      $display("FAIL no_timeout: access=%0d psel=%b busy=%b v=%b want >=300 1 1 0", cnt, psel, busy, rsp_valid);
    else n_pass++;
    sresetn = 1'b0;
    @(negedge pclk);
    sresetn = 1'b1;
    @(negedge pclk);
`endif
    n_total++;
    if ({busy, req_ready} !== 2'b01) $display("FAIL timeout_idle: busy=%b rr=%b want 0 1", busy, req_ready);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      run_xfer(1'($urandom), 7'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
               8'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
